mic1_mem_arbiter: RTL and testbench

- Shares one single-ported synchronous RAM (1-cycle read latency) between three requesters:
  - the mic1 data port (read/write);
  - the mic1 instruction-fetch port (byte);
  - a host loader/debug port.
- Stalls the core through its `run` input until every memory operation it requested in a cycle has completed.
- Sits between mic1 and the RAM in the top level. The top-level run request passes through this block.

---
 rtl/mic1_mem_pkg.sv | 53 +++++
 rtl/mic1_byte_select.sv | 20 ++
 rtl/mic1_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mic1_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_mem_pkg.sv
// Shared types and constants for the mic1 memory arbiter: FSM states,
// pending-op mask, op priority encoding and bus widths.
package mic1_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE,
    ST_H_CAPTURE
  } state_t;

  // Encoded in ascending priority: write beats read beats fetch.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_FETCH,
    OP_READ,
    OP_WRITE
  } op_t;

  typedef struct packed {
    logic write;
    logic read;
    logic fetch;
  } op_mask_t;

  function automatic op_t pick_op(input op_mask_t m);
    op_t op;
    if (m.write)      op = OP_WRITE;
    else if (m.read)  op = OP_READ;
    else if (m.fetch) op = OP_FETCH;
    else              op = OP_NONE;
    return op;
  endfunction

  function automatic op_mask_t clear_op(input op_mask_t m, input op_t op);
    op_mask_t r;
    r = m;
    case (op)
      OP_WRITE: r.write = 1'b0;
      OP_READ:  r.read  = 1'b0;
      OP_FETCH: r.fetch = 1'b0;
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mic1_byte_select.sv
// Picks one byte lane out of a RAM word for instruction fetch.
module mic1_byte_select
  import mic1_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  output logic [BYTE_W-1:0] lane_byte_c
);

  logic [LANE_W-1:0] idx;

  // Big-endian lane 0 is the most significant byte.
  always_comb begin
    idx         = BIG_ENDIAN ? ~lane : lane;
    lane_byte_c = word[BYTE_W*32'(idx) +: BYTE_W];
  end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// Shares one single-ported synchronous RAM between the mic1 data port,
// the instruction-fetch port and a host loader, stalling the core via run.
module mic1_mem_arbiter
  import mic1_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_in,
  output logic              core_run,
  input  logic [WORD_W-1:0] core_addr,
  input  logic [WORD_W-1:0] core_wdata,
  input  logic              core_read,
  input  logic              core_write,
  input  logic              core_fetch,
  input  logic [WORD_W-1:0] core_addr_instr,
  output logic [WORD_W-1:0] core_rdata,
  output logic [BYTE_W-1:0] core_rd_instr,
  input  logic              host_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic [WORD_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  op_mask_t          pend, pend_nx;
  op_t               cur_op, cur_op_nx;
  op_t               issue_op;
  op_mask_t          req_mask, issue_src;
  logic              do_issue;
  logic              run_c;
  logic              we_c;
  logic              ack_set;
  logic [ADDR_W-1:0] addr_c;
  logic [WORD_W-1:0] wdata_c;
  logic [BYTE_W-1:0] lane_byte_c;
  logic              unused_addr_bits;

  assign req_mask = '{write: core_write, read: core_read, fetch: core_fetch};

  // Address bits above the RAM size are ignored, so accesses wrap.
  assign unused_addr_bits = ^{core_addr[WORD_W-1:ADDR_W],
                              core_addr_instr[WORD_W-1:ADDR_W+2]};

  mic1_byte_select #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_byte_select (
    .word        (ram_rdata),
    .lane        (core_addr_instr[LANE_W-1:0]),
    .lane_byte_c (lane_byte_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      pend   <= '0;
      cur_op <= OP_NONE;
    end else begin
      state  <= state_nx;
      pend   <= pend_nx;
      cur_op <= cur_op_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pend_nx   = pend;
    cur_op_nx = cur_op;
    issue_op  = OP_NONE;
    issue_src = '0;
    do_issue  = 1'b0;
    run_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    ack_set   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (host_en) begin
          // The ack cycle is skipped so a host still holding req is not re-served.
          if (host_req && !host_ack) begin
            addr_c  = host_addr;
            we_c    = host_we;
            wdata_c = host_wdata;
            if (host_we) ack_set  = 1'b1;
            else         state_nx = ST_H_CAPTURE;
          end
        end else if (req_mask != '0) begin
          do_issue  = 1'b1;
          issue_src = req_mask;
        end else begin
          run_c = run_in;
        end
      end
      ST_ISSUE: begin
        do_issue  = 1'b1;
        issue_src = pend;
      end
      ST_CAPTURE: begin
        state_nx = (pend != '0) ? ST_ISSUE : ST_DONE;
      end
      ST_DONE: begin
        if (run_in && !host_en) begin
          run_c    = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_H_CAPTURE: begin
        ack_set  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (do_issue) begin
      issue_op  = pick_op(issue_src);
      pend_nx   = clear_op(issue_src, issue_op);
      cur_op_nx = issue_op;
      if (issue_op == OP_READ || issue_op == OP_FETCH) state_nx = ST_CAPTURE;
      else if (pend_nx != '0)                          state_nx = ST_ISSUE;
      else                                             state_nx = ST_DONE;
    end

    case (issue_op)
      OP_WRITE: begin
        addr_c  = core_addr[ADDR_W-1:0];
        we_c    = 1'b1;
        wdata_c = core_wdata;
      end
      OP_READ:  addr_c = core_addr[ADDR_W-1:0];
      OP_FETCH: addr_c = core_addr_instr[ADDR_W+1:2];
      default:  ;
    endcase
  end

  // Reset gating keeps a pending write from reaching the RAM while resetn is low.
  assign core_run  = resetn & run_c;
  assign ram_we    = resetn & we_c;
  assign ram_addr  = resetn ? addr_c  : '0;
  assign ram_wdata = resetn ? wdata_c : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_rdata    <= '0;
      core_rd_instr <= '0;
      host_rdata    <= '0;
      host_ack      <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      host_ack <= ack_set;
      if (state == ST_CAPTURE && cur_op == OP_READ)  core_rdata    <= ram_rdata;
      if (state == ST_CAPTURE && cur_op == OP_FETCH) core_rd_instr <= lane_byte_c;
      if (state == ST_H_CAPTURE)                     host_rdata    <= ram_rdata;
      if (run_in && !core_run && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Randomised self-checking bench for mic1_mem_arbiter: big- and little-endian
// instances run in lockstep against a word-array reference model.
module tb_mic1_mem_arbiter;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, run_in, core_read, core_write, core_fetch;
  logic          host_en, host_req, host_we;
  logic [31:0]   core_addr, core_wdata, core_addr_instr, host_wdata;
  logic [AW-1:0] host_addr;

  logic          core_run, ram_we, host_ack;
  logic [31:0]   core_rdata, host_rdata, ram_wdata, ram_rdata, stall_cycles;
  logic [7:0]    core_rd_instr;
  logic [AW-1:0] ram_addr;

  logic          core_run_le, ram_we_le, host_ack_le;
  logic [31:0]   core_rdata_le, host_rdata_le, ram_wdata_le, ram_rdata_le, stall_cycles_le;
  logic [7:0]    core_rd_instr_le;
  logic [AW-1:0] ram_addr_le;

  logic [31:0]   mem_be  [0:65535];
  logic [31:0]   mem_le  [0:65535];
  logic [31:0]   ref_mem [0:65535];
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [31:0]   bk_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata;
  logic [7:0]  exp_be, exp_le;

  mic1_mem_arbiter #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .run_in(run_in), .core_run(core_run),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_read(core_read),
    .core_write(core_write), .core_fetch(core_fetch), .core_addr_instr(core_addr_instr),
    .core_rdata(core_rdata), .core_rd_instr(core_rd_instr), .host_en(host_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cycles(stall_cycles)
  );

  mic1_mem_arbiter #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .resetn(resetn), .run_in(run_in), .core_run(core_run_le),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_read(core_read),
    .core_write(core_write), .core_fetch(core_fetch), .core_addr_instr(core_addr_instr),
    .core_rdata(core_rdata_le), .core_rd_instr(core_rd_instr_le), .host_en(host_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata_le), .host_ack(host_ack_le),
    .ram_addr(ram_addr_le), .ram_we(ram_we_le), .ram_wdata(ram_wdata_le),
    .ram_rdata(ram_rdata_le), .stall_cycles(stall_cycles_le)
  );

  // Synchronous RAMs with a backdoor preload port.
  always_ff @(posedge clk) begin
    if (bk_we) begin
      mem_be[bk_addr] <= bk_data;
      mem_le[bk_addr] <= bk_data;
    end else begin
      if (ram_we)    mem_be[ram_addr]    <= ram_wdata;
      if (ram_we_le) mem_le[ram_addr_le] <= ram_wdata_le;
    end
    ram_rdata    <= mem_be[ram_addr];
    ram_rdata_le <= mem_le[ram_addr_le];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [31:0] w, input logic [1:0] lane,
                                            input bit be);
    int sh;
    sh = be ? 8 * (3 - int'(lane)) : 8 * int'(lane);
    return 8'(w >> sh);
  endfunction

  task automatic backdoor(input logic [15:0] a, input logic [31:0] d);
    bk_addr = a; bk_data = d; bk_we = 1'b1;
    @(negedge clk);
    bk_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // One core memory cycle; called at a negedge with the arbiter idle.
  task automatic core_txn(input logic w, input logic r, input logic f,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    int          stalls, we_cnt, exp_stalls;
    logic        first_we;
    logic [15:0] da, fa, first_addr, exp_addr;
    logic [31:0] sc0, sc0_le, word;
    da = a[15:0];
    fa = pc[17:2];
    exp_stalls = (w ? 1 : 0) + (r ? 2 : 0) + (f ? 2 : 0);
    exp_addr   = (w || r) ? da : fa;
    if (w) ref_mem[da] = wd;
    if (r) exp_rdata = ref_mem[da];
    if (f) begin
      word   = ref_mem[fa];
      exp_be = model_byte(word, pc[1:0], 1'b1);
      exp_le = model_byte(word, pc[1:0], 1'b0);
    end
    sc0 = stall_cycles; sc0_le = stall_cycles_le;
    core_write = w; core_read = r; core_fetch = f;
    core_addr = a; core_wdata = wd; core_addr_instr = pc;
    #1;
    first_we = ram_we; first_addr = ram_addr;
    stalls = 0; we_cnt = 0;
    while (!core_run && stalls < 12) begin
      if (ram_we) we_cnt++;
      stalls++;
      @(negedge clk);
    end
    check("core_run_done", 32'(core_run), 32'd1);
    check("core_run_done_le", 32'(core_run_le), 32'd1);
    check("stall_len", 32'(stalls), 32'(exp_stalls));
    check("we_first", 32'(first_we), 32'(w));
    check("we_count", 32'(we_cnt), 32'(w));
    check("first_addr", 32'(first_addr), 32'(exp_addr));
    check("core_rdata", core_rdata, exp_rdata);
    check("rd_instr_be", 32'(core_rd_instr), 32'(exp_be));
    check("rd_instr_le", 32'(core_rd_instr_le), 32'(exp_le));
    @(negedge clk);
    check("stall_cnt", stall_cycles - sc0, 32'(exp_stalls));
    check("stall_cnt_le", stall_cycles_le - sc0_le, 32'(exp_stalls));
    core_write = 1'b0; core_read = 1'b0; core_fetch = 1'b0;
  endtask

  // One host access; caller holds host_en high.
  task automatic host_access(input logic we, input logic [15:0] a, input logic [31:0] d);
    int cyc;
    if (we) ref_mem[a] = d;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    #1;
    check("host_core_run", 32'(core_run), 32'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check("host_core_run", 32'(core_run), 32'd0);
    end while (!host_ack && cyc < 8);
    check("host_ack", 32'(host_ack), 32'd1);
    check("host_ack_le", 32'(host_ack_le), 32'd1);
    check("host_lat", 32'(cyc), we ? 32'd1 : 32'd2);
    if (!we) begin
      check("host_rdata", host_rdata, ref_mem[a]);
      check("host_rdata_le", host_rdata_le, ref_mem[a]);
    end
    host_req = 1'b0;
    @(negedge clk);
    check("host_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, r, f, hw;
    logic [31:0] a, pc, wd;
    logic [15:0] ha;
    int cyc;
    resetn = 1'b0; run_in = 1'b1;
    core_read = 1'b0; core_write = 1'b0; core_fetch = 1'b0;
    core_addr = '0; core_wdata = '0; core_addr_instr = '0;
    host_en = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    exp_rdata = '0; exp_be = '0; exp_le = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    resetn = 1'b1;
    #1;
    check("idle_run", 32'(core_run), 32'd1);

    for (int i = 0; i < 16; i++) backdoor(16'(i), $urandom());
    backdoor(16'd5, 32'hCAFEBABE);
    backdoor(16'd1, 32'h11223344);

    core_txn(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0);
    check("tp_read", core_rdata, 32'hCAFEBABE);
    core_txn(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd6);
    check("tp_fetch_be", 32'(core_rd_instr), 32'h33);
    check("tp_fetch_le", 32'(core_rd_instr_le), 32'h22);
    core_txn(1'b1, 1'b1, 1'b1, 32'd2, 32'hA5A5A5A5, 32'd8);
    check("tp_wrf", core_rdata, 32'hA5A5A5A5);

    host_en = 1'b1;
    host_access(1'b1, 16'd3, 32'h0000BEEF);
    host_access(1'b0, 16'd3, 32'd0);
    check("tp_host", host_rdata, 32'h0000BEEF);
    host_en = 1'b0;

    // host_en raised while a core read is in CAPTURE.
    exp_rdata = ref_mem[9];
    core_read = 1'b1; core_addr = 32'd9;
    @(negedge clk);
    host_en = 1'b1;
    @(negedge clk);
    check("hold_done_run0", 32'(core_run), 32'd0);
    @(negedge clk);
    check("hold_done_run1", 32'(core_run), 32'd0);
    check("hold_no_ack", 32'(host_ack), 32'd0);
    host_en = 1'b0;
    #1;
    check("hold_release_run", 32'(core_run), 32'd1);
    check("hold_release_data", core_rdata, exp_rdata);
    @(negedge clk);
    core_read = 1'b0;

    // Reset asserted while a write is being issued.
    core_write = 1'b1; core_addr = 32'd7; core_wdata = 32'h12345678;
    #1;
    check("rst_pre_we", 32'(ram_we), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_we", 32'(ram_we), 32'd0);
    check("rst_mid_addr", 32'(ram_addr), 32'd0);
    check("rst_mid_wdata", ram_wdata, 32'd0);
    check("rst_mid_run", 32'(core_run), 32'd0);
    check("rst_mid_rdata", core_rdata, 32'd0);
    check("rst_mid_instr", 32'(core_rd_instr), 32'd0);
    check("rst_mid_hrdata", host_rdata, 32'd0);
    check("rst_mid_stall", stall_cycles, 32'd0);
    @(negedge clk);
    check("rst_no_write", mem_be[7], ref_mem[7]);
    core_write = 1'b0;
    resetn = 1'b1;
    exp_rdata = '0; exp_be = '0; exp_le = '0;
    #1;
    check("rst_idle_run", 32'(core_run), 32'd1);
    @(negedge clk);
    core_txn(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        hw = 1'(($urandom_range(0, 1)));
        ha = 16'($urandom_range(0, 15));
        host_en = 1'b1;
        host_access(hw, ha, $urandom());
        host_en = 1'b0;
      end
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if (!(w || r || f)) r = 1'b1;
      a  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 15));
      pc = ($urandom() & 32'hFFFC_0000) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      wd = $urandom();
      core_txn(w, r, f, a, wd, pc);
    end

    // Run held low in DONE keeps the core stalled without counting stalls.
    cyc = int'(stall_cycles);
    run_in = 1'b0;
    core_read = 1'b1; core_addr = 32'd4; exp_rdata = ref_mem[4];
    repeat (4) @(negedge clk);
    check("run0_hold", 32'(core_run), 32'd0);
    check("run0_nocount", stall_cycles, 32'(cyc));
    run_in = 1'b1;
    #1;
    check("run1_release", 32'(core_run), 32'd1);
    check("run1_data", core_rdata, exp_rdata);
    @(negedge clk);
    core_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
